// File: rtl/block_ram_responder.sv
// block_ram_responder
//   Backing-memory responder behind the cache's miss/write-back interface.
//   Accepts single-word writes and block-fill reads; returns a whole block of
//   BLOCK_SIZE words on ram_data with a one-cycle ram_valid pulse,
//   READ_LATENCY edges after the read was accepted.
//
// Ports
//   clk          clock, all state on posedge
//   reset_n      asynchronous active-low reset (memory array is not cleared)
//   address      word address; offset bits ignored for reads
//   read_en      block-fill request (level, held by requester while busy)
//   write_data   word to write
//   write_en     single-word write
//   ram_valid    one-cycle pulse when ram_data carries a fresh block
//   ram_data     [i] = word (base + i); holds the last block between responses
//   busy         high while a read is outstanding (state != IDLE)
//   read_count   (BLOCK_RAM_RESP_STATS_EN only) saturating accepted-read count
//   write_count  (BLOCK_RAM_RESP_STATS_EN only) saturating accepted-write count
//
// Configuration
//   `define BLOCK_RAM_RESP_STATS_EN adds the read/write statistics counters.
//
// Handshake: requests are only sampled in IDLE. read_en and write_en in the
// same IDLE edge both take effect, and the returned block includes the new
// word. Anything presented in READ_WAIT or RESP is ignored; the requester
// keeps read_en asserted until it sees ram_valid.
module block_ram_responder #(
  parameter int RAM_ADDRESS_BITS = 10,
  parameter int DATA_BITS        = 32,
  parameter int BLOCK_BITS       = 2,
  parameter int READ_LATENCY     = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [RAM_ADDRESS_BITS-1:0] address,
  input  logic                        read_en,
  input  logic [DATA_BITS-1:0]        write_data,
  input  logic                        write_en,
  output logic                        ram_valid,
  output logic [DATA_BITS-1:0]        ram_data [(2**BLOCK_BITS)-1:0],
  output logic                        busy
`ifdef BLOCK_RAM_RESP_STATS_EN
  ,
  output logic [15:0]                 read_count,
  output logic [15:0]                 write_count
`endif
);

  localparam int DEPTH      = 2 ** RAM_ADDRESS_BITS;
  localparam int BLOCK_SIZE = 2 ** BLOCK_BITS;
  localparam int CNT_BITS   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ_WAIT = 2'd1,
    ST_RESP      = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic                        w_accept_read;
  logic                        w_accept_write;
  logic                        w_load_resp;
  logic [RAM_ADDRESS_BITS-1:0] r_base;
  logic [CNT_BITS-1:0]         r_cnt;

  // The array holds (word ^ address). An all-zero power-up array therefore
  // reads back as mem[a] = a without any initialisation logic, and the array
  // itself needs no reset.
  logic [DATA_BITS-1:0]        r_mem [DEPTH];

  assign busy = (r_state != ST_IDLE);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next state and control strobes
  always_comb begin
    w_state_next   = r_state;
    w_accept_read  = 1'b0;
    w_accept_write = 1'b0;
    w_load_resp    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept_write = write_en;
        if (read_en) begin
          w_accept_read = 1'b1;
          w_state_next  = ST_READ_WAIT;
        end
      end
      ST_READ_WAIT: begin
        if (r_cnt == '0) begin
          w_load_resp  = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Memory array write port (no reset: contents survive reset)
  always_ff @(posedge clk) begin
    if (w_accept_write) r_mem[address] <= write_data ^ DATA_BITS'(address);
  end

  // Request latch, latency counter and response register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base    <= '0;
      r_cnt     <= '0;
      ram_valid <= 1'b0;
      for (int i = 0; i < BLOCK_SIZE; i++) ram_data[i] <= '0;
    end else begin
      ram_valid <= w_load_resp;
      if (w_accept_read) begin
        r_base <= {address[RAM_ADDRESS_BITS-1:BLOCK_BITS], {BLOCK_BITS{1'b0}}};
        r_cnt  <= CNT_BITS'(READ_LATENCY - 1);
      end else if (r_state == ST_READ_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // base is block aligned, so base + i never leaves the block
      if (w_load_resp) begin
        for (int i = 0; i < BLOCK_SIZE; i++) begin
          ram_data[i] <= r_mem[r_base + RAM_ADDRESS_BITS'(i)]
                         ^ DATA_BITS'(r_base + RAM_ADDRESS_BITS'(i));
        end
      end
    end
  end

`ifdef BLOCK_RAM_RESP_STATS_EN
  logic [15:0] r_read_count;
  logic [15:0] r_write_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_read_count  <= '0;
      r_write_count <= '0;
    end else begin
      if (w_accept_read && r_read_count != 16'hFFFF)
        r_read_count <= r_read_count + 16'd1;
      if (w_accept_write && r_write_count != 16'hFFFF)
        r_write_count <= r_write_count + 16'd1;
    end
  end

  assign read_count  = r_read_count;
  assign write_count = r_write_count;
`endif

endmodule

// File: tb/tb_block_ram_responder.sv
module tb_block_ram_responder;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int BB   = 2;
  localparam int BS   = 4;
  localparam int LAT  = 4;
  localparam int DEP  = 1024;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] address;
  logic          read_en;
  logic [DW-1:0] write_data;
  logic          write_en;
  logic          ram_valid;
  logic [DW-1:0] ram_data [BS-1:0];
  logic          busy;
`ifdef BLOCK_RAM_RESP_STATS_EN
  logic [15:0]   read_count;
  logic [15:0]   write_count;
`endif

  block_ram_responder #(
    .RAM_ADDRESS_BITS(AW), .DATA_BITS(DW), .BLOCK_BITS(BB), .READ_LATENCY(LAT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .read_en    (read_en),
    .write_data (write_data),
    .write_en   (write_en),
    .ram_valid  (ram_valid),
    .ram_data   (ram_data),
    .busy       (busy)
`ifdef BLOCK_RAM_RESP_STATS_EN
    ,
    .read_count (read_count),
    .write_count(write_count)
`endif
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [DW-1:0] model [DEP];
  int            n_vec = 0;
  int            n_err = 0;
  int            exp_rd = 0;
  int            exp_wr = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // response monitor: sampled on the falling edge
  always @(negedge clk) begin
    if (reset_n === 1'b1 && ram_valid === 1'b1) begin
      if (exp_cyc_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        int ec;
        ec = exp_cyc_q.pop_front();
        check("valid_cycle", 32'(cyc), 32'(ec));
        for (int i = 0; i < BS; i++)
          check($sformatf("ram_data[%0d]", i), ram_data[i], exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic wait_idle();
    int n;
    n = 0;
    @(posedge clk); #2;
    while (busy !== 1'b0 && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 50) check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  function automatic void push_block(input logic [AW-1:0] a, input int accept_cyc);
    logic [AW-1:0] base;
    base = {a[AW-1:BB], 2'b00};
    for (int i = 0; i < BS; i++) exp_q.push_back(model[base + AW'(i)]);
    exp_cyc_q.push_back(accept_cyc + LAT);
  endfunction

  // one-cycle read request, optionally with a simultaneous write
  task automatic do_read(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d);
    wait_idle();
    address = a; read_en = 1'b1; write_en = wr; write_data = d;
    if (wr) begin
      model[a] = d;
      exp_wr++;
    end
    exp_rd++;
    push_block(a, cyc + 1);
    @(posedge clk); #2;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    read_en = 1'b0; write_en = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_idle();
    address = a; write_en = 1'b1; write_data = d;
    model[a] = d;
    exp_wr++;
    @(posedge clk); #2;
    write_en = 1'b0;
    check("busy_after_write", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n0;
    for (int a = 0; a < DEP; a++) model[a] = DW'(a);
    reset_n = 1'b0; address = '0; read_en = 1'b0; write_en = 1'b0; write_data = '0;

    // reset state
    repeat (3) @(posedge clk);
    #2;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, ram_valid}, 32'd0);
    for (int i = 0; i < BS; i++) check($sformatf("reset_data[%0d]", i), ram_data[i], 32'd0);
    reset_n = 1'b1;

    // 1: basic block fill, offset bits ignored
    do_read(10'h013, 1'b0, '0);
    // 2: write top word, read top block; data holds afterwards
    do_write(10'h3FF, 32'hDEADBEEF);
    do_read(10'h3FC, 1'b0, '0);
    wait_idle();
    repeat (3) @(posedge clk);
    #2;
    check("hold_data[3]", ram_data[3], 32'hDEADBEEF);
    check("hold_data[0]", ram_data[0], 32'h000003FC);
    // 3: simultaneous read + write
    do_read(10'h021, 1'b1, 32'hA5A5A5A5);
    // 4: write during READ_WAIT is ignored
    do_read(10'h080, 1'b0, '0);
    address = 10'h040; write_data = 32'h1; write_en = 1'b1;
    @(posedge clk); #2;
    write_en = 1'b0;
    do_read(10'h040, 1'b0, '0);
    // random reads
    for (int k = 0; k < 4; k++) do_read(AW'($urandom_range(0, DEP - 1)), 1'b0, '0);
    // held read_en: back-to-back fills every LAT+2 cycles
    wait_idle();
    address = 10'h055; read_en = 1'b1;
    n0 = cyc;
    push_block(10'h055, n0 + 1);
    push_block(10'h055, n0 + 1 + LAT + 2);
    exp_rd += 2;
    repeat (LAT + 3) @(posedge clk);
    #2;
    read_en = 1'b0;

    // 5: reset in the middle of READ_WAIT
    do_read(10'h200, 1'b0, '0);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_valid", {31'd0, ram_valid}, 32'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    exp_rd = 0;
    exp_wr = 0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    #2;
    check("post_reset_data[0]", ram_data[0], 32'd0);
    do_read(10'h100, 1'b0, '0);
    do_read(10'h3FE, 1'b0, '0);  // memory survives reset

`ifdef BLOCK_RAM_RESP_STATS_EN
    // 6: statistics
    do_write(10'h0A0, 32'h12345678);
    do_read(10'h0A1, 1'b1, 32'h87654321);
    wait_idle();
    check("read_count", {16'd0, read_count}, 32'(exp_rd));
    check("write_count", {16'd0, write_count}, 32'(exp_wr));
    force dut.r_read_count = 16'hFFFF;
    @(posedge clk); #2;
    release dut.r_read_count;
    do_read(10'h0A4, 1'b0, '0);
    wait_idle();
    check("read_count_sat", {16'd0, read_count}, 32'h0000FFFF);
`endif

    wait_idle();
    repeat (LAT + 4) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_cyc_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
